mem_bist_ctrl: RTL and testbench

Built-in self-test sequencer that sits directly upstream of the single-port memory and drives its valid/ready request port. On start it writes a selected data pattern to every address, then reads every address back and compares each result with the expected value. It reports done, pass/fail, an error count and the first failing address. It is the synthesizable replacement for bench-driven write/read sweeps.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_bist_pattern.sv | 33 +++
 rtl/mem_bist_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared controller states and pattern codes for the memory BIST.
// The MARCH_DN and VERIFY states exist only when MEM_BIST_MARCH_EN is defined.
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
`ifdef MEM_BIST_MARCH_EN
      MARCH_DN,
      VERIFY,
`endif
      DRAIN,
      DONE
   } state_t;

   localparam logic [1:0] PAT_WALK1 = 2'd0;
   localparam logic [1:0] PAT_WALK0 = 2'd1;
   localparam logic [1:0] PAT_ADDR  = 2'd2;
   localparam logic [1:0] PAT_CHECK = 2'd3;

endpackage

// File: rtl/mem_bist_pattern.sv
// mem_bist_pattern: combinational expected-data generator for one address.
// Walking one/zero positions repeat every WIDTH addresses; the checkerboard
// has its MSB set on even addresses and flips on odd ones.
module mem_bist_pattern
   import mem_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ADDR  = 4
) (
   input  logic [1:0]       sel_i,
   input  logic [ADDR-1:0]  addr_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] walkOne;
   logic [WIDTH-1:0] chkData;

   // Build every candidate pattern for this address, then pick the selected one
   always_comb begin
      walkOne = {{(WIDTH-1){1'b0}}, 1'b1} << (int'(addr_i) % WIDTH);
      chkData = '0;
      for (int i = 0; i < WIDTH; i++) begin
         chkData[i] = ((((WIDTH - 1 - i) % 2) == 0) ^ addr_i[0]);
      end
      case (sel_i)
         PAT_WALK1: data_o = walkOne;
         PAT_WALK0: data_o = ~walkOne;
         PAT_ADDR:  data_o = WIDTH'(addr_i);
         default:   data_o = chkData;
      endcase
   end

endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: BIST sequencer driving a single-port memory request port.
// Writes a pattern everywhere, reads it back, compares through an RD_LAT-deep
// pipe and reports pass/fail, an error count and the first failing address.
// Optional MEM_BIST_MARCH_EN adds a descending read/write-inverse march and an
// ascending verify pass of the inverted data.
module mem_bist_ctrl
   import mem_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR   = $clog2(DEPTH),
   parameter int RD_LAT = 1,
   parameter int CNT_W  = ADDR + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       pattern_sel_i,
   output logic             valid_o,
   output logic             wr_rd_o,
   output logic [ADDR-1:0]  addr_o,
   output logic [WIDTH-1:0] wdata_o,
   input  logic             ready_i,
   input  logic [WIDTH-1:0] rdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [ADDR-1:0]  first_err_addr_o
);

   localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [ADDR-1:0]  addr_q, addr_d;
   logic             valid_q, valid_d;
   logic             wrRd_q, wrRd_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
`ifdef MEM_BIST_MARCH_EN
   logic             marchWr_q, marchWr_d;
`endif

   logic             accept;
   logic             startAcc;
   logic             push;
   logic             pushInv;
   logic             loadWdata;
   logic             invWdata;
   logic [WIDTH-1:0] pushExp;
   logic [WIDTH-1:0] patData;

   logic [RD_LAT-1:0] pipeVld_q;
   logic [WIDTH-1:0]  pipeExp_q  [RD_LAT];
   logic [ADDR-1:0]   pipeAddr_q [RD_LAT];
   logic              pipeBusy;
   logic              mismatch;
   logic [CNT_W-1:0]  errCnt_q;
   logic [ADDR-1:0]   firstErr_q;

   assign accept   = valid_q & ready_i;
   assign pipeBusy = |pipeVld_q;
   assign mismatch = pipeVld_q[RD_LAT-1] && (rdata_i != pipeExp_q[RD_LAT-1]);

   // Expected data always follows the next request address, so exp_q matches addr_q
   mem_bist_pattern #(
      .WIDTH (WIDTH),
      .ADDR  (ADDR)
   ) uPattern (
      .sel_i  (sel_d),
      .addr_i (addr_d),
      .data_o (patData)
   );

   // Sequencing: next state, next request and the status flags set on completion
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      addr_d    = addr_q;
      valid_d   = valid_q;
      wrRd_d    = wrRd_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      startAcc  = 1'b0;
      push      = 1'b0;
      pushInv   = 1'b0;
      loadWdata = 1'b0;
      invWdata  = 1'b0;
`ifdef MEM_BIST_MARCH_EN
      marchWr_d = marchWr_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               startAcc  = 1'b1;
               sel_d     = pattern_sel_i;
               addr_d    = '0;
               valid_d   = 1'b1;
               wrRd_d    = 1'b1;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               loadWdata = 1'b1;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            if (accept) begin
               loadWdata = 1'b1;
               if (addr_q == LAST_ADDR) begin
                  addr_d  = '0;
                  wrRd_d  = 1'b0;
                  state_d = READ;
               end else begin
                  addr_d = addr_q + ADDR'(1);
               end
            end
         end
         READ: begin
            if (accept) begin
               push      = 1'b1;
               loadWdata = 1'b1;
               if (addr_q == LAST_ADDR) begin
`ifdef MEM_BIST_MARCH_EN
                  addr_d    = LAST_ADDR;
                  marchWr_d = 1'b0;
                  state_d   = MARCH_DN;
`else
                  valid_d = 1'b0;
                  state_d = DRAIN;
`endif
               end else begin
                  addr_d = addr_q + ADDR'(1);
               end
            end
         end
`ifdef MEM_BIST_MARCH_EN
         MARCH_DN: begin
            if (accept) begin
               if (!marchWr_q) begin
                  push      = 1'b1;
                  marchWr_d = 1'b1;
                  wrRd_d    = 1'b1;
                  invWdata  = 1'b1;
               end else begin
                  marchWr_d = 1'b0;
                  wrRd_d    = 1'b0;
                  loadWdata = 1'b1;
                  if (addr_q == '0) begin
                     state_d = VERIFY;
                  end else begin
                     addr_d = addr_q - ADDR'(1);
                  end
               end
            end
         end
         VERIFY: begin
            if (accept) begin
               push      = 1'b1;
               pushInv   = 1'b1;
               loadWdata = 1'b1;
               if (addr_q == LAST_ADDR) begin
                  valid_d = 1'b0;
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + ADDR'(1);
               end
            end
         end
`endif
         DRAIN: begin
            if (!pipeBusy) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (errCnt_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Data path: write data holds through stalls and only changes when a request moves on
   always_comb begin
      exp_d   = patData;
      wdata_d = wdata_q;
      if (loadWdata) begin
         wdata_d = patData;
      end
      if (invWdata) begin
         wdata_d = ~exp_q;
      end
      pushExp = pushInv ? ~exp_q : exp_q;
   end

   // State and request registers; everything the memory sees is driven from here
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         wrRd_q  <= 1'b0;
         wdata_q <= '0;
         exp_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         wrRd_q  <= wrRd_d;
         wdata_q <= wdata_d;
         exp_q   <= exp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

`ifdef MEM_BIST_MARCH_EN
   // March sub-phase: read first, then write the inverse to the same address
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         marchWr_q <= 1'b0;
      end else begin
         marchWr_q <= marchWr_d;
      end
   end
`endif

   // Compare pipe: each accepted read carries its expected data and address until rdata_i arrives
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pipeVld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipeExp_q[i]  <= '0;
            pipeAddr_q[i] <= '0;
         end
      end else begin
         pipeVld_q[0]  <= push;
         pipeExp_q[0]  <= pushExp;
         pipeAddr_q[0] <= addr_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pipeVld_q[i]  <= pipeVld_q[i-1];
            pipeExp_q[i]  <= pipeExp_q[i-1];
            pipeAddr_q[i] <= pipeAddr_q[i-1];
         end
      end
   end

   // Error bookkeeping: saturating count, first failing address captured once per test
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         errCnt_q   <= '0;
         firstErr_q <= '0;
      end else if (startAcc) begin
         errCnt_q   <= '0;
         firstErr_q <= '0;
      end else if (mismatch) begin
         if (errCnt_q != '1) begin
            errCnt_q <= errCnt_q + CNT_W'(1);
         end
         if (errCnt_q == '0) begin
            firstErr_q <= pipeAddr_q[RD_LAT-1];
         end
      end
   end

   assign valid_o          = valid_q;
   assign wr_rd_o          = wrRd_q;
   assign addr_o           = addr_q;
   assign wdata_o          = wdata_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign pass_o           = pass_q;
   assign err_count_o      = errCnt_q;
   assign first_err_addr_o = firstErr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: directed bench for mem_bist_ctrl with a behavioural memory
// that can force selected read bits to 0. The march scenario runs only when
// MEM_BIST_MARCH_EN is defined.
module tb_mem_bist_ctrl;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR   = 4;
   localparam int RD_LAT = 1;
   localparam int CNT_W  = 5;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic [1:0]       pattern_sel_i = 2'd0;
   logic             valid_o;
   logic             wr_rd_o;
   logic [ADDR-1:0]  addr_o;
   logic [WIDTH-1:0] wdata_o;
   logic             ready_i = 1'b1;
   logic [WIDTH-1:0] rdata_i = '0;
   logic             busy_o;
   logic             done_o;
   logic             pass_o;
   logic [CNT_W-1:0] err_count_o;
   logic [ADDR-1:0]  first_err_addr_o;

   int checks = 0;
   int errors = 0;

   int reqCount = 0;
   int stallCnt = 0;
   int stallErr = 0;

   logic [WIDTH-1:0] mem    [DEPTH];
   logic [WIDTH-1:0] lastWr [DEPTH];

   logic             faultAll  = 1'b0;
   logic [ADDR-1:0]  faultAddr = '0;
   logic [WIDTH-1:0] faultMask = '0;

   logic             heldV = 1'b0;
   logic [ADDR-1:0]  heldA = '0;
   logic [WIDTH-1:0] heldD = '0;
   logic             heldW = 1'b0;

   mem_bist_ctrl #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR   (ADDR),
      .RD_LAT (RD_LAT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .start_i          (start_i),
      .pattern_sel_i    (pattern_sel_i),
      .valid_o          (valid_o),
      .wr_rd_o          (wr_rd_o),
      .addr_o           (addr_o),
      .wdata_o          (wdata_o),
      .ready_i          (ready_i),
      .rdata_i          (rdata_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .pass_o           (pass_o),
      .err_count_o      (err_count_o),
      .first_err_addr_o (first_err_addr_o)
   );

   always #5 clk = ~clk;

   // Single-port memory with one-cycle read latency and an optional stuck-at-0 read fault
   always @(posedge clk) begin
      if (rst_i && valid_o && ready_i) begin
         if (wr_rd_o) begin
            mem[addr_o] <= wdata_o;
         end else begin
            rdata_i <= mem[addr_o] & ~(((faultAll == 1'b1) || (addr_o == faultAddr)) ? faultMask : '0);
         end
      end
   end

   // Request monitor: counts accepted requests, logs writes and watches stalled requests stay put
   always @(posedge clk) begin
      if (rst_i && valid_o && ready_i) begin
         reqCount++;
         if (wr_rd_o) begin
            lastWr[addr_o] = wdata_o;
         end
      end
      if (rst_i && heldV) begin
         if (valid_o !== 1'b1 || addr_o !== heldA || wdata_o !== heldD || wr_rd_o !== heldW) begin
            stallErr++;
         end
      end
      heldV = rst_i && valid_o && !ready_i;
      if (heldV) begin
         stallCnt++;
      end
      heldA = addr_o;
      heldD = wdata_o;
      heldW = wr_rd_o;
   end

   // Global watchdog so a wedged run still ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Start one test and wait (bounded) for done_o; cycles counts clock edges after the start edge
   task automatic applyStimulus(input logic [1:0] sel, input bit randReady, input int extraAt,
                                input int budget, output int cycles, output int reqs,
                                output bit timedOut);
      int reqStart;
      @(negedge clk);
      reqStart      = reqCount;
      pattern_sel_i = sel;
      start_i       = 1'b1;
      ready_i       = 1'b1;
      @(posedge clk);
      cycles   = 0;
      timedOut = 1'b0;
      forever begin
         @(negedge clk);
         start_i = (cycles + 1 == extraAt);
         if (randReady) begin
            ready_i = ($urandom_range(0, 9) >= 4);
         end
         @(posedge clk);
         #1;
         cycles++;
         if (done_o === 1'b1) break;
         if (cycles >= budget) begin
            timedOut = 1'b1;
            break;
         end
      end
      @(negedge clk);
      start_i = 1'b0;
      ready_i = 1'b1;
      reqs    = reqCount - reqStart;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({valid_o, wr_rd_o, busy_o, done_o, pass_o} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b want 00000", {valid_o, wr_rd_o, busy_o, done_o, pass_o});
      end
      checks++;
      if ({addr_o, wdata_o} !== 12'h0) begin
         errors++;
         $display("[TB] FAIL reset_req got addr %0d wdata %h want 0 0", addr_o, wdata_o);
      end
      checks++;
      if ({err_count_o, first_err_addr_o} !== 9'h0) begin
         errors++;
         $display("[TB] FAIL reset_status got err %0d first %0d want 0 0", err_count_o, first_err_addr_o);
      end
      rst_i = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_walk1();
      int cyc, reqs;
      bit to;
      applyStimulus(2'd0, 1'b0, 0, 200, cyc, reqs, to);
      checks++;
      if (to !== 1'b0) begin errors++; $display("[TB] FAIL walk1_timeout got %0b want 0", to); end
      checks++;
      if (cyc !== 35) begin errors++; $display("[TB] FAIL walk1_latency got %0d want 35", cyc); end
      checks++;
      if (reqs !== 32) begin errors++; $display("[TB] FAIL walk1_reqs got %0d want 32", reqs); end
      checks++;
      if (lastWr[9] !== 8'h02) begin errors++; $display("[TB] FAIL walk1_wdata9 got %h want 02", lastWr[9]); end
      checks++;
      if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL walk1_pass got %0b want 1", pass_o); end
      checks++;
      if (err_count_o !== 5'd0) begin errors++; $display("[TB] FAIL walk1_err got %0d want 0", err_count_o); end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL walk1_busy got %0b want 0", busy_o); end
   endtask

   task automatic test_stuck_fault();
      int cyc, reqs;
      bit to;
      faultAll  = 1'b0;
      faultAddr = 4'd5;
      faultMask = 8'h08;
      // walk-0 at address 5 is DF: bit 3 is 1, so the fault shows
      applyStimulus(2'd1, 1'b0, 0, 200, cyc, reqs, to);
      checks++;
      if (err_count_o !== 5'd1) begin errors++; $display("[TB] FAIL stuck_walk0_err got %0d want 1", err_count_o); end
      checks++;
      if (first_err_addr_o !== 4'd5) begin errors++; $display("[TB] FAIL stuck_walk0_first got %0d want 5", first_err_addr_o); end
      checks++;
      if (pass_o !== 1'b0) begin errors++; $display("[TB] FAIL stuck_walk0_pass got %0b want 0", pass_o); end
      // walk-1 at address 5 is 20: bit 3 is 0, fault hidden
      applyStimulus(2'd0, 1'b0, 0, 200, cyc, reqs, to);
      checks++;
      if (err_count_o !== 5'd0) begin errors++; $display("[TB] FAIL stuck_walk1_err got %0d want 0", err_count_o); end
      checks++;
      if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL stuck_walk1_pass got %0b want 1", pass_o); end
      // checkerboard at odd address 5 is 55: bit 3 is 0, fault hidden
      applyStimulus(2'd3, 1'b0, 0, 200, cyc, reqs, to);
      checks++;
      if (err_count_o !== 5'd0) begin errors++; $display("[TB] FAIL stuck_check_err got %0d want 0", err_count_o); end
      checks++;
      if ({pass_o, first_err_addr_o} !== 5'b1_0000) begin errors++; $display("[TB] FAIL stuck_check_pass got %0b/%0d want 1/0", pass_o, first_err_addr_o); end
      faultMask = '0;
   endtask

   task automatic test_multi_error();
      int cyc, reqs;
      bit to;
      // bit 0 stuck low everywhere, addr-as-data: the 8 odd addresses fail, first is 1
      faultAll  = 1'b1;
      faultMask = 8'h01;
      applyStimulus(2'd2, 1'b0, 0, 200, cyc, reqs, to);
      checks++;
      if (err_count_o !== 5'd8) begin errors++; $display("[TB] FAIL multi_err got %0d want 8", err_count_o); end
      checks++;
      if (first_err_addr_o !== 4'd1) begin errors++; $display("[TB] FAIL multi_first got %0d want 1", first_err_addr_o); end
      checks++;
      if (pass_o !== 1'b0) begin errors++; $display("[TB] FAIL multi_pass got %0b want 0", pass_o); end
      faultAll  = 1'b0;
      faultMask = '0;
   endtask

   task automatic test_stall();
      int cyc, reqs, s0, e0;
      bit to;
      s0 = stallCnt;
      e0 = stallErr;
      applyStimulus(2'd2, 1'b1, 0, 2000, cyc, reqs, to);
      checks++;
      if (to !== 1'b0) begin errors++; $display("[TB] FAIL stall_timeout got %0b want 0", to); end
      checks++;
      if (reqs !== 32) begin errors++; $display("[TB] FAIL stall_reqs got %0d want 32", reqs); end
      checks++;
      if (stallCnt - s0 == 0) begin errors++; $display("[TB] FAIL stall_seen got %0d stalls want >0", stallCnt - s0); end
      checks++;
      if (stallErr - e0 !== 0) begin errors++; $display("[TB] FAIL stall_stable got %0d changes want 0", stallErr - e0); end
      checks++;
      if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_pass got %0b want 1", pass_o); end
      checks++;
      if (lastWr[12] !== 8'h0C) begin errors++; $display("[TB] FAIL stall_wdata12 got %h want 0c", lastWr[12]); end
   endtask

   task automatic test_start_ignore();
      int cyc, reqs, r0;
      bit to;
      // extra start in the middle of WRITE
      applyStimulus(2'd0, 1'b0, 10, 200, cyc, reqs, to);
      r0 = reqCount;
      repeat (5) @(negedge clk);
      checks++;
      if (cyc !== 35) begin errors++; $display("[TB] FAIL busy_start_latency got %0d want 35", cyc); end
      checks++;
      if (reqs !== 32) begin errors++; $display("[TB] FAIL busy_start_reqs got %0d want 32", reqs); end
      checks++;
      if ({busy_o, done_o} !== 2'b01 || reqCount !== r0) begin
         errors++;
         $display("[TB] FAIL busy_start_idle got busy %0b done %0b extra %0d want 0 1 0", busy_o, done_o, reqCount - r0);
      end
      // extra start exactly in the DONE cycle
      applyStimulus(2'd0, 1'b0, 35, 200, cyc, reqs, to);
      r0 = reqCount;
      repeat (5) @(negedge clk);
      checks++;
      if (cyc !== 35) begin errors++; $display("[TB] FAIL done_start_latency got %0d want 35", cyc); end
      checks++;
      if ({busy_o, done_o} !== 2'b01 || reqCount !== r0) begin
         errors++;
         $display("[TB] FAIL done_start_idle got busy %0b done %0b extra %0d want 0 1 0", busy_o, done_o, reqCount - r0);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, reqs;
      bit to, found;
      @(negedge clk);
      pattern_sel_i = 2'd0;
      start_i       = 1'b1;
      ready_i       = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (valid_o === 1'b1 && wr_rd_o === 1'b1 && addr_o === 4'd7) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (found !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_reach got %0b want 1", found); end
      #2;
      rst_i = 1'b0;
      #1;
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %0b want 0", valid_o); end
      checks++;
      if ({wr_rd_o, busy_o, done_o, pass_o, addr_o, wdata_o, err_count_o, first_err_addr_o} !== 25'h0) begin
         errors++;
         $display("[TB] FAIL rstmid_outputs got busy %0b addr %0d wdata %h err %0d want all 0", busy_o, addr_o, wdata_o, err_count_o);
      end
      @(negedge clk);
      rst_i = 1'b1;
      applyStimulus(2'd0, 1'b0, 0, 200, cyc, reqs, to);
      checks++;
      if (cyc !== 35) begin errors++; $display("[TB] FAIL rstmid_rerun_latency got %0d want 35", cyc); end
      checks++;
      if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_rerun_pass got %0b want 1", pass_o); end
   endtask

`ifdef MEM_BIST_MARCH_EN
   task automatic test_march();
      int cyc, reqs;
      bit to;
      applyStimulus(2'd0, 1'b0, 0, 400, cyc, reqs, to);
      checks++;
      if (reqs !== 80) begin errors++; $display("[TB] FAIL march_reqs got %0d want 80", reqs); end
      checks++;
      if (cyc !== 83) begin errors++; $display("[TB] FAIL march_latency got %0d want 83", cyc); end
      checks++;
      if (lastWr[15] !== 8'h7F) begin errors++; $display("[TB] FAIL march_wdata15 got %h want 7f", lastWr[15]); end
      checks++;
      if (pass_o !== 1'b1) begin errors++; $display("[TB] FAIL march_pass got %0b want 1", pass_o); end
   endtask
`endif

   initial begin
      #2;
      test_reset();
      test_walk1();
      test_stuck_fault();
      test_multi_error();
      test_stall();
      test_start_ignore();
      test_reset_mid();
`ifdef MEM_BIST_MARCH_EN
      test_march();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
